// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: fetch PC owner for the 5-stage core.
// Issues instruction-memory requests and advances the fetch PC on each
// accepted, unstalled request. It steers fetch to the EX-resolved target on
// a taken branch or jump and flushes IF/ID and ID/EX in that same cycle.
// A saturating redirect counter and a sticky misaligned-target flag are
// kept for debug visibility.
module pc_redirect_ctrl #(
   parameter int                  REG_SIZE = 32,
   parameter logic [REG_SIZE-1:0] RESET_PC = '0,
   parameter int                  CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                PC_R,
   input  logic                JMP,
   input  logic [REG_SIZE-1:0] TARGET,
   input  logic                STALL,
   input  logic                IMEM_READY,
   output logic                IMEM_REQ,
   output logic [REG_SIZE-1:0] PC_F,
   output logic                FETCH_VALID,
   output logic                FLUSH_D,
   output logic                FLUSH_E,
   output logic                MISALIGN,
   output logic [CNT_W-1:0]    REDIRECT_CNT
);

   // IDLE only lasts for the first cycle after reset; FETCH and WAIT both
   // hold a live request and differ only in whether the memory last stalled.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [REG_SIZE-1:0] pc_reg, pc_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic                misalign_reg, misalign_next;

   logic                redirect;
   logic                active;
   logic                accept;
   logic                advance;
   logic                take_redirect;
   logic [REG_SIZE-1:0] target_aligned;
   logic [REG_SIZE-1:0] pc_plus4;

   // A redirect is any taken control transfer resolved in EX; both sources
   // together still count as one redirect.
   assign redirect       = PC_R | JMP;
   assign active         = (state_reg != ST_IDLE);
   assign accept         = IMEM_REQ & IMEM_READY;
   assign advance        = accept & ~STALL & ~redirect;
   assign take_redirect  = redirect & active;

   // The low two bits are dropped rather than trapping; the sticky flag
   // records that it happened.
   assign target_aligned = {TARGET[REG_SIZE-1:2], 2'b00};

   // Natural modulo-2^REG_SIZE wrap past the top of the address space.
   assign pc_plus4       = pc_reg + REG_SIZE'(4);

   // Outputs are pure functions of state and inputs so an asynchronous reset
   // takes effect on them without waiting for an edge.
   assign IMEM_REQ       = active;
   assign FETCH_VALID    = advance;
   assign FLUSH_D        = take_redirect;
   assign FLUSH_E        = take_redirect;
   assign PC_F           = pc_reg;
   assign MISALIGN       = misalign_reg;
   assign REDIRECT_CNT   = cnt_reg;

   // State and PC register; the reset returns fetch to RESET_PC in IDLE.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= ST_IDLE;
         pc_reg    <= RESET_PC;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   // Next-state and next-PC: redirect beats stall, and stall beats advance.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         ST_IDLE: begin
            // Redirects are ignored here; there is no request to abandon.
            state_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (redirect) begin
               pc_next    = target_aligned;
               state_next = ST_FETCH;
            end else if (advance) begin
               pc_next    = pc_plus4;
            end else if (!IMEM_READY) begin
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (redirect) begin
               // The request still pending at the old PC is dropped.
               pc_next    = target_aligned;
               state_next = ST_FETCH;
            end else if (advance) begin
               pc_next    = pc_plus4;
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_IDLE;
            pc_next    = RESET_PC;
         end
      endcase
   end

   // Debug next-values: the counter saturates at all-ones and the flag sticks.
   always_comb begin
      cnt_next      = cnt_reg;
      misalign_next = misalign_reg;
      if (take_redirect) begin
         if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + CNT_W'(1);
         end
         if (TARGET[1:0] != 2'b00) begin
            misalign_next = 1'b1;
         end
      end
   end

   // Debug registers; only reset clears them.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_reg      <= '0;
         misalign_reg <= 1'b0;
      end else begin
         cnt_reg      <= cnt_next;
         misalign_reg <= misalign_next;
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: directed vector table, hand-written multi-cycle
// sequences (async reset mid-wait, counter saturation) and a randomized run
// checked against a compact behavioural model of the fetch PC.
module tb_pc_redirect_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        PC_R = 1'b0;
   logic        JMP = 1'b0;
   logic [31:0] TARGET = '0;
   logic        STALL = 1'b0;
   logic        IMEM_READY = 1'b0;
   logic        IMEM_REQ;
   logic [31:0] PC_F;
   logic        FETCH_VALID;
   logic        FLUSH_D;
   logic        FLUSH_E;
   logic        MISALIGN;
   logic [15:0] REDIRECT_CNT;

   int errors = 0;
   int checks = 0;

   pc_redirect_ctrl #(
      .REG_SIZE (32),
      .RESET_PC (32'h0000_0000),
      .CNT_W    (16)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .PC_R         (PC_R),
      .JMP          (JMP),
      .TARGET       (TARGET),
      .STALL        (STALL),
      .IMEM_READY   (IMEM_READY),
      .IMEM_REQ     (IMEM_REQ),
      .PC_F         (PC_F),
      .FETCH_VALID  (FETCH_VALID),
      .FLUSH_D      (FLUSH_D),
      .FLUSH_E      (FLUSH_E),
      .MISALIGN     (MISALIGN),
      .REDIRECT_CNT (REDIRECT_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        pcr;
      logic        jmp;
      logic [31:0] tgt;
      logic        stall;
      logic        ready;
      logic        e_req;
      logic [31:0] e_pc;
      logic        e_fv;
      logic        e_fl;
      logic        e_mis;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NVEC = 27;
   vec_t vecs [NVEC];

   // Behavioural model: has fetch started, where is it, and the debug state.
   bit          m_started;
   logic [31:0] m_pc;
   bit          m_mis;
   int          m_cnt;

   function automatic vec_t mk(input logic pcr, input logic jmp, input logic [31:0] tgt,
                               input logic stall, input logic ready, input logic req,
                               input logic [31:0] pc, input logic fv, input logic fl,
                               input logic mis, input logic [15:0] cnt);
      vec_t v;
      v.pcr = pcr; v.jmp = jmp; v.tgt = tgt; v.stall = stall; v.ready = ready;
      v.e_req = req; v.e_pc = pc; v.e_fv = fv; v.e_fl = fl; v.e_mis = mis; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic pcr, input logic jmp, input logic [31:0] tgt,
                        input logic stall, input logic ready);
      PC_R = pcr; JMP = jmp; TARGET = tgt; STALL = stall; IMEM_READY = ready;
   endtask

   // Hold reset across a few edges, then release just after an edge.
   task automatic do_reset(input int n);
      RST = 1'b1;
      drive(0, 0, 32'h0, 0, 1);
      repeat (n) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   task automatic rnd_cycle();
      logic        pcr, jmp, stall, ready, redir, fv;
      logic [31:0] tgt;
      pcr   = ($urandom_range(0, 7) == 0);
      jmp   = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 3) != 0);
      tgt   = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFFC;
      drive(pcr, jmp, tgt, stall, ready);
      @(negedge CLK);
      redir = pcr | jmp;
      fv    = m_started && ready && !stall && !redir;
      chk("rnd_req",   IMEM_REQ,     m_started);
      chk("rnd_pc",    PC_F,         m_pc);
      chk("rnd_fv",    FETCH_VALID,  fv);
      chk("rnd_fld",   FLUSH_D,      redir && m_started);
      chk("rnd_fle",   FLUSH_E,      redir && m_started);
      chk("rnd_mis",   MISALIGN,     m_mis);
      chk("rnd_cnt",   REDIRECT_CNT, 32'(m_cnt));
      if (!m_started) begin
         m_started = 1'b1;
      end else if (redir) begin
         m_pc = {tgt[31:2], 2'b00};
         if (m_cnt < 65535) m_cnt++;
         if (tgt[1:0] != 2'b00) m_mis = 1'b1;
      end else if (fv) begin
         m_pc = m_pc + 32'd4;
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      // inputs: pcr jmp target stall ready | expected: req pc fv flush mis cnt
      vecs[0]  = mk(0, 0, 32'h0,         0, 1,  0, 32'h0,         0, 0, 0, 16'd0);
      vecs[1]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h0,         1, 0, 0, 16'd0);
      vecs[2]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h4,         1, 0, 0, 16'd0);
      vecs[3]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h8,         1, 0, 0, 16'd0);
      vecs[4]  = mk(0, 0, 32'h0,         0, 1,  1, 32'hC,         1, 0, 0, 16'd0);
      vecs[5]  = mk(1, 0, 32'h100,       0, 1,  1, 32'h10,        0, 1, 0, 16'd0);
      vecs[6]  = mk(0, 0, 32'h0,         0, 1,  1, 32'h100,       1, 0, 0, 16'd1);
      vecs[7]  = mk(1, 0, 32'h20,        0, 1,  1, 32'h104,       0, 1, 0, 16'd1);
      vecs[8]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h20,        0, 0, 0, 16'd2);
      vecs[9]  = mk(0, 0, 32'h0,         1, 1,  1, 32'h20,        0, 0, 0, 16'd2);
      vecs[10] = mk(0, 1, 32'h46,        1, 1,  1, 32'h20,        0, 1, 0, 16'd2);
      vecs[11] = mk(0, 0, 32'h0,         0, 1,  1, 32'h44,        1, 0, 1, 16'd3);
      vecs[12] = mk(1, 0, 32'h30,        0, 1,  1, 32'h48,        0, 1, 1, 16'd3);
      vecs[13] = mk(0, 0, 32'h0,         0, 0,  1, 32'h30,        0, 0, 1, 16'd4);
      vecs[14] = mk(0, 0, 32'h0,         0, 0,  1, 32'h30,        0, 0, 1, 16'd4);
      vecs[15] = mk(0, 0, 32'h0,         0, 0,  1, 32'h30,        0, 0, 1, 16'd4);
      vecs[16] = mk(1, 0, 32'h200,       0, 0,  1, 32'h30,        0, 1, 1, 16'd4);
      vecs[17] = mk(0, 0, 32'h0,         0, 1,  1, 32'h200,       1, 0, 1, 16'd5);
      vecs[18] = mk(1, 0, 32'hFFFF_FFFC, 0, 1,  1, 32'h204,       0, 1, 1, 16'd5);
      vecs[19] = mk(0, 0, 32'h0,         0, 1,  1, 32'hFFFF_FFFC, 1, 0, 1, 16'd6);
      vecs[20] = mk(0, 0, 32'h0,         0, 1,  1, 32'h0,         1, 0, 1, 16'd6);
      vecs[21] = mk(1, 1, 32'h8,         0, 1,  1, 32'h4,         0, 1, 1, 16'd6);
      vecs[22] = mk(0, 0, 32'h0,         0, 1,  1, 32'h8,         1, 0, 1, 16'd7);
      vecs[23] = mk(0, 0, 32'h0,         0, 0,  1, 32'hC,         0, 0, 1, 16'd7);
      vecs[24] = mk(0, 0, 32'h0,         1, 1,  1, 32'hC,         0, 0, 1, 16'd7);
      vecs[25] = mk(0, 0, 32'h0,         0, 1,  1, 32'hC,         1, 0, 1, 16'd7);
      vecs[26] = mk(0, 0, 32'h0,         0, 1,  1, 32'h10,        1, 0, 1, 16'd7);

      // ---- directed table ----
      do_reset(3);
      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].pcr, vecs[i].jmp, vecs[i].tgt, vecs[i].stall, vecs[i].ready);
         @(negedge CLK);
         chk($sformatf("v%0d_req", i), IMEM_REQ,     vecs[i].e_req);
         chk($sformatf("v%0d_pc", i),  PC_F,         vecs[i].e_pc);
         chk($sformatf("v%0d_fv", i),  FETCH_VALID,  vecs[i].e_fv);
         chk($sformatf("v%0d_fld", i), FLUSH_D,      vecs[i].e_fl);
         chk($sformatf("v%0d_fle", i), FLUSH_E,      vecs[i].e_fl);
         chk($sformatf("v%0d_mis", i), MISALIGN,     vecs[i].e_mis);
         chk($sformatf("v%0d_cnt", i), REDIRECT_CNT, vecs[i].e_cnt);
         $display("vec %0d: pcr=%0b jmp=%0b tgt=%h stall=%0b rdy=%0b -> pc=%h fv=%0b flush=%0b cnt=%0d",
                  i, vecs[i].pcr, vecs[i].jmp, vecs[i].tgt, vecs[i].stall, vecs[i].ready,
                  PC_F, FETCH_VALID, FLUSH_D, REDIRECT_CNT);
         @(posedge CLK);
         #1;
      end

      // ---- async reset in the middle of WAIT during a redirect ----
      drive(0, 0, 32'h0, 0, 0);          // PC 0x14, memory not ready -> WAIT
      @(posedge CLK);
      #1;
      drive(1, 0, 32'h55, 0, 0);
      #1;
      chk("arst_pre_flush", FLUSH_D, 1'b1);
      #1 RST = 1'b1;
      #1;
      chk("arst_req",   IMEM_REQ,     1'b0);
      chk("arst_pc",    PC_F,         32'h0);
      chk("arst_mis",   MISALIGN,     1'b0);
      chk("arst_cnt",   REDIRECT_CNT, 16'd0);
      chk("arst_fld",   FLUSH_D,      1'b0);
      chk("arst_fle",   FLUSH_E,      1'b0);
      chk("arst_fv",    FETCH_VALID,  1'b0);
      $display("async reset mid-wait: pc=%h req=%0b mis=%0b cnt=%0d", PC_F, IMEM_REQ, MISALIGN, REDIRECT_CNT);
      @(posedge CLK);
      #1 RST = 1'b0;

      // ---- redirect in IDLE is ignored, then 65537 redirects saturate ----
      drive(1, 0, 32'h40, 0, 1);
      @(negedge CLK);
      chk("idle_flush", FLUSH_D, 1'b0);
      chk("idle_req",   IMEM_REQ, 1'b0);
      @(posedge CLK);
      #1;
      for (int i = 0; i < 65537; i++) begin
         @(negedge CLK);
         if (i == 0)     chk("sat_idle_ignored", REDIRECT_CNT, 16'd0);
         if (i == 65534) chk("sat_before",       REDIRECT_CNT, 16'hFFFE);
         @(posedge CLK);
         #1;
      end
      @(negedge CLK);
      chk("sat_cnt", REDIRECT_CNT, 16'hFFFF);
      chk("sat_pc",  PC_F,         32'h40);
      @(posedge CLK);
      #1;
      drive(0, 0, 32'h0, 0, 1);
      @(negedge CLK);
      chk("sat_hold", REDIRECT_CNT, 16'hFFFF);
      $display("saturation: 65538 redirects -> cnt=%h", REDIRECT_CNT);
      @(posedge CLK);
      #1;

      // ---- randomized run against the model ----
      do_reset(1);
      m_started = 1'b0;
      m_pc      = 32'h0;
      m_mis     = 1'b0;
      m_cnt     = 0;
      for (int i = 0; i < 3000; i++) begin
         rnd_cycle();
      end
      $display("random: 3000 cycles, final pc=%h cnt=%0d mis=%0b", PC_F, REDIRECT_CNT, MISALIGN);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Fetch-side consumer of the EX-stage branch decision (PC_R) and jump signals for the 5-stage RISC-V core.
- Owns the fetch PC register and drives the instruction-memory request handshake.
- On a taken branch or jump, redirects fetch to the EX-computed target and flushes the two younger stages.
- Keeps a saturating redirect counter and a sticky misaligned-target flag for debug.

Parameters:
REG_SIZE, 32, PC/target width (matches `REG_SIZE)
RESET_PC, 32'h0000_0000, fetch address after reset
CNT_W, 16, width of REDIRECT_CNT

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-high
PC_R  input  1  branch taken, from EX branch-condition logic
JMP  input  1  unconditional jump (JAL/JALR) resolved in EX
TARGET  input  REG_SIZE  redirect target computed in EX
STALL  input  1  hazard stall from hazard unit
IMEM_READY  input  1  instruction memory accepts request this cycle
IMEM_REQ  output  1  fetch request valid
PC_F  output  REG_SIZE  current fetch address
FETCH_VALID  output  1  instruction at PC_F captured into IF/ID this edge
FLUSH_D  output  1  clear IF/ID at this edge
FLUSH_E  output  1  clear ID/EX at this edge
MISALIGN  output  1  sticky: a redirect target had TARGET[1:0] != 0
REDIRECT_CNT  output  CNT_W  number of redirects taken, saturating

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (CLK, RST).
- Reset values: PC_F=RESET_PC, state=IDLE, IMEM_REQ=0, FETCH_VALID=0, FLUSH_D=FLUSH_E=0, MISALIGN=0, REDIRECT_CNT=0.
- Internal signals:
  - redirect = PC_R | JMP.
  - accept = IMEM_REQ & IMEM_READY.
- Priority, highest first: RST > redirect > STALL > normal advance.
- FSM states: IDLE, FETCH, WAIT.
  - IDLE: IMEM_REQ=0. Moves to FETCH on the first edge after RST deasserts. A redirect seen in IDLE is ignored.
  - FETCH: IMEM_REQ=1.
    - accept & ~STALL & ~redirect: PC_F <= PC_F+4; stay in FETCH.
    - ~IMEM_READY & ~redirect: go to WAIT; PC_F held.
  - WAIT: IMEM_REQ=1 at the same PC_F.
    - IMEM_READY & ~STALL & ~redirect: PC_F <= PC_F+4; go to FETCH.
    - Otherwise stay in WAIT.
- Redirect in FETCH or WAIT:
  - PC_F <= {TARGET[REG_SIZE-1:2],2'b00}; next state FETCH.
  - Any unaccepted request is abandoned.
  - STALL is ignored that cycle.
- FLUSH_D = FLUSH_E = redirect & (state != IDLE), combinational, same cycle as PC_R/JMP.
- FETCH_VALID = accept & ~STALL & ~redirect, combinational. It is never high in a flush cycle.
- STALL without redirect: PC_F held, FETCH_VALID=0, IMEM_REQ stays 1, state unchanged.
- MISALIGN: set on a redirect with TARGET[1:0]!=0. Only reset clears it.
- REDIRECT_CNT: +1 per redirect cycle outside IDLE; holds at all-ones (no wrap).
- PC_F+4 wraps modulo 2^REG_SIZE (0xFFFFFFFC -> 0x00000000). No error is raised.
- PC_R and JMP both high: treated as a single redirect; counter increments by 1.
- RST mid-operation, including during WAIT or a redirect: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset-release sequence: RST high 3 cycles, then low; IMEM_READY=1 -> IMEM_REQ=0 for the first cycle (IDLE), then PC_F = 0x0, 0x4, 0x8 on successive cycles; FETCH_VALID=1 from the first FETCH cycle.
- Taken branch: PC_F=0x10, PC_R=1, TARGET=0x100 for one cycle -> FLUSH_D=FLUSH_E=1 and FETCH_VALID=0 that cycle; next cycle PC_F=0x100; REDIRECT_CNT=1.
- Stall vs redirect: STALL=1 with PC_F=0x20 for 2 cycles -> PC_F stays 0x20, FETCH_VALID=0. Then STALL=1 and JMP=1 with TARGET=0x46 -> PC_F=0x44 next cycle; MISALIGN=1 and stays 1.
- Memory wait: IMEM_READY=0 for 3 cycles at PC_F=0x30 -> state WAIT, PC_F=0x30, IMEM_REQ=1. Then PC_R=1, TARGET=0x200 while still waiting -> PC_F=0x200, state FETCH.
- Wrap and saturation:
  - PC_F=0xFFFFFFFC, accept -> PC_F=0x0.
  - Force 65537 redirects -> REDIRECT_CNT=0xFFFF.
- Async reset mid-WAIT: assert RST between clock edges -> PC_F=RESET_PC, IMEM_REQ=0, MISALIGN=0, REDIRECT_CNT=0 before the next edge.
